// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  // Requester IDs, used both for the last-granted register and the mux select
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/nmux21.sv
// N-bit 2:1 mux, purely combinational (0 cycles); y = s ? b : a.
// No flow control: output follows inputs every cycle.
module nmux21 #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mem_arb21.sv
// Round-robin 2:1 arbiter for one memory port; grant 1 cycle after req, ack same cycle as mem_ready.
// Backpressure: the owner holds the grant until mem_ready, with no preemption.
module mem_arb21
  import mem_arb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] wdata0,
  input  logic         we0,
  input  logic         req1,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] wdata1,
  input  logic         we1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         ack0,
  output logic         ack1,
  output logic [N-1:0] rdata,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata
);

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   sel;
  logic   we_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= REQ1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || last == REQ1)) begin
          state_nxt = BUSY0;
          last_nxt  = REQ0;
        end else if (req1) begin
          state_nxt = BUSY1;
          last_nxt  = REQ1;
        end
      end
      BUSY0: begin
        // Handing over to the other requester first gives strict alternation
        if (mem_ready) begin
          if (req1) begin
            state_nxt = BUSY1;
            last_nxt  = REQ1;
          end else if (!req0) begin
            state_nxt = IDLE;
          end
        end
      end
      BUSY1: begin
        if (mem_ready) begin
          if (req0) begin
            state_nxt = BUSY0;
            last_nxt  = REQ0;
          end else if (!req1) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt0    = (state == BUSY0);
  assign gnt1    = (state == BUSY1);
  assign mem_req = gnt0 | gnt1;
  assign ack0    = mem_ready & gnt0;
  assign ack1    = mem_ready & gnt1;
  assign rdata   = mem_rdata;
  assign sel     = (state == BUSY1);

  nmux21 #(.N(N)) u_addr_mux (
    .a (addr0),
    .b (addr1),
    .s (sel),
    .y (mem_addr)
  );

  nmux21 #(.N(N)) u_wdata_mux (
    .a (wdata0),
    .b (wdata1),
    .s (sel),
    .y (mem_wdata)
  );

  nmux21 #(.N(1)) u_we_mux (
    .a (we0),
    .b (we1),
    .s (sel),
    .y (we_mux)
  );

  // A stray write enable must never reach memory while the port is idle
  assign mem_we = we_mux & mem_req;

endmodule

// File: tb/tb_mem_arb21.sv
// Directed bench for mem_arb21: reset, single read, contention, write routing, reissue, mid-transaction reset.
module tb_mem_arb21;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, we0, we1;
  logic [N-1:0] addr0, addr1, wdata0, wdata1;
  logic         gnt0, gnt1, ack0, ack1;
  logic [N-1:0] rdata;
  logic         mem_req, mem_we, mem_ready;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arb21 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .we0       (we0),
    .req1      (req1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .we1       (we1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // A granted requester dropping req before its ack is a protocol violation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ((gnt0 && !req0 && !ack0) || (gnt1 && !req1 && !ack1))) begin
      total++;
      $error("FAIL proto_req_drop observed gnt0=%b req0=%b gnt1=%b req1=%b", gnt0, req0, gnt1, req1);
    end
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'hAAAAAAAA; addr1 = 32'hBBBBBBBB;
    wdata0 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset held for 2 cycles with both requesting
    cyc(); cyc();
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_mem_we", mem_we, 0);
    rst_n = 1'b1;
    cyc();
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1", gnt1, 0);
    // Finish that transaction and go idle
    req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b1;
    #1;
    chk("tie_ack0", ack0, 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("idle_mem_req", mem_req, 0);

    // mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    #1;
    chk("idle_rdy_ack0", ack0, 0);
    chk("idle_rdy_ack1", ack1, 0);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("idle_rdy_mem_req", mem_req, 0);

    // Single read by requester 1, memory stalls 2 cycles
    req1 = 1'b1; addr1 = 32'hBBBB0000; we1 = 1'b0;
    #1;
    chk("rd_no_gnt_yet", gnt1, 0);
    cyc();
    chk("rd_gnt1", gnt1, 1);
    chk("rd_addr", mem_addr, 32'hBBBB0000);
    chk("rd_we", mem_we, 0);
    chk("rd_ack1_w0", ack1, 0);
    cyc();
    chk("rd_hold_gnt1", gnt1, 1);
    chk("rd_ack1_w1", ack1, 0);
    chk("rd_addr_w1", mem_addr, 32'hBBBB0000);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h12345678; req1 = 1'b0;
    #1;
    chk("rd_ack1", ack1, 1);
    chk("rd_ack0", ack0, 0);
    chk("rd_rdata", rdata, 32'h12345678);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("rd_ack1_gone", ack1, 0);
    chk("rd_idle", mem_req, 0);

    // Contention: both request, memory always ready; last=1 so 0 goes first
    addr0 = 32'hAAAAAAAA; addr1 = 32'hBBBBBBBB;
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1;
    cyc();
    chk("ct0_gnt0", gnt0, 1);
    chk("ct0_addr", mem_addr, 32'hAAAAAAAA);
    chk("ct0_ack0", ack0, 1);
    cyc();
    chk("ct1_gnt1", gnt1, 1);
    chk("ct1_addr", mem_addr, 32'hBBBBBBBB);
    chk("ct1_ack1", ack1, 1);
    cyc();
    chk("ct2_gnt0", gnt0, 1);
    chk("ct2_addr", mem_addr, 32'hAAAAAAAA);
    cyc();
    chk("ct3_gnt1", gnt1, 1);
    chk("ct3_addr", mem_addr, 32'hBBBBBBBB);
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("ct_idle", mem_req, 0);

    // Write routing for requester 0; requester 1 presents decoy values
    req0 = 1'b1; we0 = 1'b1; wdata0 = 32'hDEADBEEF; addr0 = 32'h00000040;
    we1 = 1'b1; wdata1 = 32'h0BADF00D; addr1 = 32'h0000FFFF;
    cyc();
    chk("wr_gnt0", gnt0, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_addr", mem_addr, 32'h00000040);
    chk("wr_ack0_wait", ack0, 0);
    mem_ready = 1'b1; req0 = 1'b0;
    #1;
    chk("wr_ack0", ack0, 1);
    chk("wr_ack1", ack1, 0);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("wr_idle_req", mem_req, 0);
    chk("wr_idle_we_gated", mem_we, 0);
    we0 = 1'b0; we1 = 1'b0;

    // Same-requester reissue, then requester 1 queues behind it
    req0 = 1'b1;
    cyc();
    chk("ri_gnt0", gnt0, 1);
    mem_ready = 1'b1;
    #1;
    chk("ri_ack0_a", ack0, 1);
    cyc();
    mem_ready = 1'b0; req1 = 1'b1;
    #1;
    chk("ri_stay_gnt0", gnt0, 1);
    chk("ri_no_gnt1", gnt1, 0);
    cyc();
    chk("ri_nopreempt", gnt0, 1);
    mem_ready = 1'b1; req0 = 1'b0;
    #1;
    chk("ri_ack0_b", ack0, 1);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("ri_handover_gnt1", gnt1, 1);
    chk("ri_handover_gnt0", gnt0, 0);

    // Mid-transaction reset while requester 1 owns the port
    req0 = 1'b1; req1 = 1'b1;
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("mr_gnt1", gnt1, 0);
    chk("mr_mem_req", mem_req, 0);
    chk("mr_ack1", ack1, 0);
    #2;
    rst_n = 1'b1; mem_ready = 1'b0;
    cyc();
    chk("mr_tie_gnt0", gnt0, 1);
    chk("mr_tie_gnt1", gnt1, 0);
    mem_ready = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("end_idle", mem_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
